param_stack: RTL and testbench
==============================

PARAM_STACK -- requirements
Module: param_stack

Interface
REQ-001 Parameter WIDTH, default 4, data word width in bits (>=1).
REQ-002 Parameter DEPTH, default 8, number of stack entries (>=2).
REQ-003 Derived CNT_W = clog2(DEPTH+1), width of count port.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rstN  input  1  asynchronous, active-low reset.
REQ-006 clr  input  1  synchronous clear of stack contents and error flags.
REQ-007 push  input  1  push request.
REQ-008 pop  input  1  pop request.
REQ-009 data_in  input  WIDTH  word to push.
REQ-010 data_out  output  WIDTH  registered word from the last successful pop.
REQ-011 out_valid  output  1  registered; one-cycle pulse when data_out is updated by a pop.
REQ-012 top  output  WIDTH  combinational peek of the top entry; 0 when empty.
REQ-013 count  output  CNT_W  number of occupied entries, 0..DEPTH.
REQ-014 full  output  1  high iff count == DEPTH.
REQ-015 empty  output  1  high iff count == 0.
REQ-016 overflow  output  1  sticky; push rejected because stack was full.
REQ-017 underflow  output  1  sticky; pop rejected because stack was empty.

Function
REQ-018 Per-edge priority: clr > (push & pop) > pop > push; exactly one action per cycle.
REQ-019 clr: count <= 0, data_out <= 0, out_valid <= 0, overflow <= 0, underflow <= 0; push/pop ignored that cycle.
REQ-020 Pop only, not empty: data_out <= entry[count-1], count <= count-1, out_valid <= 1.
REQ-021 Pop only, empty: no state change except underflow <= 1; data_out holds, out_valid <= 0.
REQ-022 Push only, not full: entry[count] <= data_in, count <= count+1, out_valid <= 0.
REQ-023 Push only, full: no write, count holds, overflow <= 1, out_valid <= 0.
REQ-024 Push & pop, not empty (including full): data_out <= entry[count-1], entry[count-1] <= data_in, count unchanged, out_valid <= 1, no flag set.
REQ-025 Push & pop, empty: entry[0] <= data_in, count <= 1, underflow <= 1, out_valid <= 0, data_out holds.
REQ-026 Neither push nor pop: all state holds; out_valid <= 0.
REQ-027 Pop latency: popped word appears on data_out and out_valid one cycle after the sampling edge.
REQ-028 Push visibility: top reflects the pushed word immediately after the sampling edge.
REQ-029 overflow and underflow clear only on reset or clr.
REQ-030 count never exceeds DEPTH nor wraps below 0; full/empty derived combinationally from count.
REQ-031 Storage array is not reset; only count, data_out, out_valid and flags are.

Reset
REQ-032 rstN low asynchronously forces count=0, data_out=0, out_valid=0, overflow=0, underflow=0, regardless of clk.
REQ-033 Reset asserted mid-operation discards in-flight push/pop; first edge after rstN deasserts is a normal operation.
REQ-034 After reset: empty=1, full=0, top=0.

Verification (WIDTH=4, DEPTH=8)
REQ-035 Push 1..8 over 8 cycles -> count=8, full=1, top=8; ninth push of 9 -> count=8, top=8, overflow=1.
REQ-036 From full 1..8, pop 8 times -> data_out sequence 8,7,..,1 each with out_valid pulse, final empty=1; ninth pop -> underflow=1, data_out stays 1.
REQ-037 Stack holds 3,5; push&pop with data_in=A -> data_out=5, out_valid=1, count=2, top=A.
REQ-038 Empty stack, push&pop with data_in=C -> count=1, top=C, underflow=1, out_valid=0.
REQ-039 With overflow=1 and count=8, assert clr -> count=0, empty=1, overflow=0, data_out=0.
REQ-040 Push 3 words, drop rstN between edges -> count=0, data_out=0 immediately; release, push 7 -> count=1, top=7.

Source files
------------

// File: rtl/param_stack_if.sv
// Bus bundle for param_stack: request inputs, registered pop result and status flags.
// Handshake: push/pop are sampled on every rising edge with no ready; a rejected request is
// reported by the sticky overflow/underflow flags, and out_valid qualifies data_out for one cycle.
interface param_stack_if #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 8
);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic             clr;
   logic             push;
   logic             pop;
   logic [WIDTH-1:0] data_in;
   logic [WIDTH-1:0] data_out;
   logic             out_valid;
   logic [WIDTH-1:0] top;
   logic [CNT_W-1:0] count;
   logic             full;
   logic             empty;
   logic             overflow;
   logic             underflow;

   modport master (
      output clr, push, pop, data_in,
      input  data_out, out_valid, top, count, full, empty, overflow, underflow
   );

   modport slave (
      input  clr, push, pop, data_in,
      output data_out, out_valid, top, count, full, empty, overflow, underflow
   );
endinterface

// File: rtl/param_stack.sv
// LIFO stack with registered pop output, combinational top-of-stack peek and sticky error flags.
// Priority per edge: clr, then simultaneous push+pop (replace top), then pop, then push.
module param_stack #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 8
) (
   input  logic          clk,
   input  logic          rstN,
   param_stack_if.slave  bus
);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int IDX_W = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [CNT_W-1:0] r_count;
   logic [WIDTH-1:0] r_data_out;
   logic             r_out_valid;
   logic             r_overflow;
   logic             r_underflow;

   logic             w_empty;
   logic             w_full;
   logic [IDX_W-1:0] w_top_idx;
   logic [IDX_W-1:0] w_wr_idx;
   logic [IDX_W-1:0] w_widx;
   logic             w_we;

   assign w_empty   = (r_count == '0);
   assign w_full    = (r_count == CNT_W'(DEPTH));
   assign w_top_idx = IDX_W'(r_count - CNT_W'(1));
   assign w_wr_idx  = IDX_W'(r_count);

   // A push lands unless full with no pop; a push+pop on a non-empty stack overwrites the top slot.
   assign w_we   = rstN && !bus.clr && bus.push && (bus.pop || !w_full);
   assign w_widx = (bus.pop && !w_empty) ? w_top_idx : w_wr_idx;

   always_ff @(posedge clk) begin
      if (w_we) begin
         r_mem[w_widx] <= bus.data_in;
      end
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         r_count     <= '0;
         r_data_out  <= '0;
         r_out_valid <= 1'b0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else if (bus.clr) begin
         r_count     <= '0;
         r_data_out  <= '0;
         r_out_valid <= 1'b0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else if (bus.push && bus.pop) begin
         if (!w_empty) begin
            r_data_out  <= r_mem[w_top_idx];
            r_out_valid <= 1'b1;
         end else begin
            r_count     <= CNT_W'(1);
            r_underflow <= 1'b1;
            r_out_valid <= 1'b0;
         end
      end else if (bus.pop) begin
         if (!w_empty) begin
            r_data_out  <= r_mem[w_top_idx];
            r_count     <= r_count - CNT_W'(1);
            r_out_valid <= 1'b1;
         end else begin
            r_underflow <= 1'b1;
            r_out_valid <= 1'b0;
         end
      end else if (bus.push) begin
         r_out_valid <= 1'b0;
         if (!w_full) begin
            r_count <= r_count + CNT_W'(1);
         end else begin
            r_overflow <= 1'b1;
         end
      end else begin
         r_out_valid <= 1'b0;
      end
   end

   assign bus.data_out  = r_data_out;
   assign bus.out_valid = r_out_valid;
   assign bus.top       = w_empty ? '0 : r_mem[w_top_idx];
   assign bus.count     = r_count;
   assign bus.full      = w_full;
   assign bus.empty     = w_empty;
   assign bus.overflow  = r_overflow;
   assign bus.underflow = r_underflow;
endmodule

// File: tb/tb_param_stack.sv
// Directed bench for param_stack (WIDTH=4, DEPTH=8): one task per scenario with inline checks.
module tb_param_stack;
   logic clk;
   logic rstN;
   int   errors;
   int   checks;
   logic [3:0] exp_q[$];

   param_stack_if #(.WIDTH(4), .DEPTH(8)) bus ();

   param_stack #(.WIDTH(4), .DEPTH(8)) dut (
      .clk  (clk),
      .rstN (rstN),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.clr = 1'b0; bus.push = 1'b0; bus.pop = 1'b0; bus.data_in = 4'd0;
   endtask

   task automatic do_push(input logic [3:0] v);
      bus.push = 1'b1; bus.data_in = v;
      step();
      bus.push = 1'b0;
   endtask

   task automatic do_clr();
      bus.clr = 1'b1;
      step();
      bus.clr = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rstN = 1'b0;
      step(); step();
      checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d exp 0", bus.count); end
      checks++; if (bus.empty !== 1'b1 || bus.full !== 1'b0) begin errors++; $display("FAIL reset_flags: empty=%b full=%b exp 1 0", bus.empty, bus.full); end
      checks++; if (bus.top !== 4'd0 || bus.data_out !== 4'd0 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_data: top=%0h data_out=%0h out_valid=%b exp 0 0 0", bus.top, bus.data_out, bus.out_valid); end
      checks++; if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin errors++; $display("FAIL reset_err: ovf=%b unf=%b exp 0 0", bus.overflow, bus.underflow); end
      rstN = 1'b1;
      step();
   endtask

   task automatic test_fill();
      for (int i = 1; i <= 8; i++) begin
         do_push(4'(i));
         exp_q.push_back(4'(i));
         checks++; if (bus.top !== 4'(i) || bus.count !== 4'(i)) begin errors++; $display("FAIL fill_%0d: top=%0h count=%0d exp %0h %0d", i, bus.top, bus.count, i, i); end
      end
      checks++; if (bus.full !== 1'b1 || bus.empty !== 1'b0) begin errors++; $display("FAIL fill_full: full=%b empty=%b exp 1 0", bus.full, bus.empty); end
      do_push(4'd9);
      checks++; if (bus.count !== 4'd8 || bus.top !== 4'd8) begin errors++; $display("FAIL overflow_hold: count=%0d top=%0h exp 8 8", bus.count, bus.top); end
      checks++; if (bus.overflow !== 1'b1 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL overflow_flag: ovf=%b out_valid=%b exp 1 0", bus.overflow, bus.out_valid); end
   endtask

   task automatic test_drain();
      logic [3:0] e;
      for (int i = 0; i < 8; i++) begin
         bus.pop = 1'b1;
         step();
         e = exp_q.pop_back();
         checks++; if (bus.data_out !== e || bus.out_valid !== 1'b1) begin errors++; $display("FAIL pop_%0d: data_out=%0h out_valid=%b exp %0h 1", i, bus.data_out, bus.out_valid, e); end
      end
      bus.pop = 1'b0;
      checks++; if (bus.empty !== 1'b1 || bus.count !== 4'd0) begin errors++; $display("FAIL drain_empty: empty=%b count=%0d exp 1 0", bus.empty, bus.count); end
      step();
      checks++; if (bus.out_valid !== 1'b0 || bus.data_out !== 4'd1) begin errors++; $display("FAIL idle_pulse: out_valid=%b data_out=%0h exp 0 1", bus.out_valid, bus.data_out); end
      bus.pop = 1'b1;
      step();
      bus.pop = 1'b0;
      checks++; if (bus.underflow !== 1'b1 || bus.data_out !== 4'd1 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL underflow: unf=%b data_out=%0h out_valid=%b exp 1 1 0", bus.underflow, bus.data_out, bus.out_valid); end
      checks++; if (bus.overflow !== 1'b1 || bus.count !== 4'd0) begin errors++; $display("FAIL sticky: ovf=%b count=%0d exp 1 0", bus.overflow, bus.count); end
   endtask

   task automatic test_clr();
      for (int i = 1; i <= 8; i++) do_push(4'(i + 2));
      do_push(4'hF);
      bus.push = 1'b1; bus.data_in = 4'hE;
      do_clr();
      bus.push = 1'b0;
      checks++; if (bus.count !== 4'd0 || bus.empty !== 1'b1 || bus.top !== 4'd0) begin errors++; $display("FAIL clr_state: count=%0d empty=%b top=%0h exp 0 1 0", bus.count, bus.empty, bus.top); end
      checks++; if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0 || bus.data_out !== 4'd0) begin errors++; $display("FAIL clr_flags: ovf=%b unf=%b data_out=%0h exp 0 0 0", bus.overflow, bus.underflow, bus.data_out); end
   endtask

   task automatic test_push_pop();
      do_push(4'd3);
      do_push(4'd5);
      bus.push = 1'b1; bus.pop = 1'b1; bus.data_in = 4'hA;
      step();
      bus.push = 1'b0; bus.pop = 1'b0;
      checks++; if (bus.data_out !== 4'd5 || bus.out_valid !== 1'b1) begin errors++; $display("FAIL pp_out: data_out=%0h out_valid=%b exp 5 1", bus.data_out, bus.out_valid); end
      checks++; if (bus.count !== 4'd2 || bus.top !== 4'hA) begin errors++; $display("FAIL pp_top: count=%0d top=%0h exp 2 a", bus.count, bus.top); end
      checks++; if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin errors++; $display("FAIL pp_flags: ovf=%b unf=%b exp 0 0", bus.overflow, bus.underflow); end
      bus.pop = 1'b1;
      step();
      bus.pop = 1'b0;
      checks++; if (bus.data_out !== 4'hA || bus.top !== 4'd3 || bus.count !== 4'd1) begin errors++; $display("FAIL pp_follow: data_out=%0h top=%0h count=%0d exp a 3 1", bus.data_out, bus.top, bus.count); end
   endtask

   task automatic test_push_pop_full();
      do_clr();
      for (int i = 1; i <= 8; i++) do_push(4'(i));
      bus.push = 1'b1; bus.pop = 1'b1; bus.data_in = 4'hB;
      step();
      bus.push = 1'b0; bus.pop = 1'b0;
      checks++; if (bus.data_out !== 4'd8 || bus.top !== 4'hB || bus.count !== 4'd8) begin errors++; $display("FAIL ppfull: data_out=%0h top=%0h count=%0d exp 8 b 8", bus.data_out, bus.top, bus.count); end
      checks++; if (bus.overflow !== 1'b0 || bus.out_valid !== 1'b1) begin errors++; $display("FAIL ppfull_flags: ovf=%b out_valid=%b exp 0 1", bus.overflow, bus.out_valid); end
   endtask

   task automatic test_push_pop_empty();
      do_clr();
      bus.push = 1'b1; bus.pop = 1'b1; bus.data_in = 4'hC;
      step();
      bus.push = 1'b0; bus.pop = 1'b0;
      checks++; if (bus.count !== 4'd1 || bus.top !== 4'hC) begin errors++; $display("FAIL ppempty_top: count=%0d top=%0h exp 1 c", bus.count, bus.top); end
      checks++; if (bus.underflow !== 1'b1 || bus.out_valid !== 1'b0 || bus.data_out !== 4'd0) begin errors++; $display("FAIL ppempty_flags: unf=%b out_valid=%b data_out=%0h exp 1 0 0", bus.underflow, bus.out_valid, bus.data_out); end
   endtask

   task automatic test_reset_mid();
      do_clr();
      do_push(4'd2);
      do_push(4'd4);
      do_push(4'd6);
      bus.pop = 1'b1;
      step();
      bus.pop = 1'b0;
      checks++; if (bus.data_out !== 4'd6 || bus.count !== 4'd2) begin errors++; $display("FAIL mid_pre: data_out=%0h count=%0d exp 6 2", bus.data_out, bus.count); end
      bus.push = 1'b1; bus.data_in = 4'd9;
      rstN = 1'b0;
      #1;
      checks++; if (bus.count !== 4'd0 || bus.data_out !== 4'd0 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL async_rst: count=%0d data_out=%0h out_valid=%b exp 0 0 0", bus.count, bus.data_out, bus.out_valid); end
      step();
      checks++; if (bus.count !== 4'd0 || bus.empty !== 1'b1 || bus.top !== 4'd0) begin errors++; $display("FAIL rst_hold: count=%0d empty=%b top=%0h exp 0 1 0", bus.count, bus.empty, bus.top); end
      bus.push = 1'b0;
      rstN = 1'b1;
      do_push(4'd7);
      checks++; if (bus.count !== 4'd1 || bus.top !== 4'd7) begin errors++; $display("FAIL post_rst: count=%0d top=%0h exp 1 7", bus.count, bus.top); end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      rstN = 1'b0;
      idle_inputs();
      test_reset();
      test_fill();
      test_drain();
      test_clr();
      test_push_pop();
      test_push_pop_full();
      test_push_pop_empty();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
